// File: rtl/grf_pkg.sv
// Shared sizing and types for the general register file scoreboard.
package grf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned CNT_W  = 6;

    typedef logic [DATA_W-1:0] regfile_t [NREG];

endpackage

// File: rtl/grf_pending.sv
// Pending-producer bit per register plus a running count of pending registers.
module grf_pending #(
    parameter int unsigned NREG = grf_pkg::NREG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        iss_en,
    input  logic [grf_pkg::ADDR_W-1:0]  iss_addr,
    input  logic                        we,
    input  logic [grf_pkg::ADDR_W-1:0]  wa,
    output logic [NREG-1:0]             pending,
    output logic [grf_pkg::CNT_W-1:0]   pend_cnt
);
    import grf_pkg::*;

    logic            set_c;
    logic            clr_c;
    logic            inc_c;
    logic            dec_c;
    logic [NREG-1:0] pending_nxt;

    // Issue is applied after writeback so a same-address issue keeps the bit set
    always_comb begin
        set_c       = iss_en && (iss_addr != '0);
        clr_c       = we && (wa != '0);
        pending_nxt = pending;
        if (clr_c) pending_nxt[wa] = 1'b0;
        if (set_c) pending_nxt[iss_addr] = 1'b1;
        inc_c = set_c && !pending[iss_addr];
        dec_c = clr_c && pending[wa] && !(set_c && (iss_addr == wa));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if (inc_c && !dec_c) begin
                pend_cnt <= pend_cnt + CNT_W'(1);
            end else if (dec_c && !inc_c) begin
                pend_cnt <= pend_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// Register file with per-register pending tracking and combinational reads.
// Define GRF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module grf_scoreboard #(
    parameter int unsigned DATA_W = grf_pkg::DATA_W,
    parameter int unsigned NREG   = grf_pkg::NREG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [grf_pkg::ADDR_W-1:0]  ra1,
    input  logic [grf_pkg::ADDR_W-1:0]  ra2,
    output logic [DATA_W-1:0]           rd1,
    output logic [DATA_W-1:0]           rd2,
    output logic                        rd1_rdy,
    output logic                        rd2_rdy,
    input  logic                        iss_en,
    input  logic [grf_pkg::ADDR_W-1:0]  iss_addr,
    input  logic                        we,
    input  logic [grf_pkg::ADDR_W-1:0]  wa,
    input  logic [DATA_W-1:0]           wd,
    output logic [grf_pkg::CNT_W-1:0]   pend_cnt
);
    import grf_pkg::*;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic              wr_c;

    assign wr_c = we && (wa != '0);

    grf_pending #(.NREG(NREG)) u_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .we       (we),
        .wa       (wa),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_c) begin
            regs[wa] <= wd;
        end
    end

    // Register 0 is hardwired to zero and never pending
    always_comb begin
        rd1     = '0;
        rd1_rdy = 1'b1;
        rd2     = '0;
        rd2_rdy = 1'b1;
        if (ra1 != '0) begin
            rd1     = regs[ra1];
            rd1_rdy = ~pending[ra1];
        end
        if (ra2 != '0) begin
            rd2     = regs[ra2];
            rd2_rdy = ~pending[ra2];
        end
`ifdef GRF_BYPASS_EN
        // A same-cycle issue to the written register makes it a new pending producer
        if (wr_c && (ra1 == wa)) begin
            rd1     = wd;
            rd1_rdy = ~(iss_en && (iss_addr == wa));
        end
        if (wr_c && (ra2 == wa)) begin
            rd2     = wd;
            rd2_rdy = ~(iss_en && (iss_addr == wa));
        end
`endif
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against an array/queue-level reference model.
module tb_grf_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        rd1_rdy, rd2_rdy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    grf_scoreboard dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rd1_rdy  (rd1_rdy),
        .rd2_rdy  (rd2_rdy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .pend_cnt (pend_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: architectural register contents and the set of pending registers
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    end

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef GRF_BYPASS_EN
        if (we && wa != 0 && a == wa) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_rdy(input logic [4:0] a);
        if (a == 0) return 1'b1;
`ifdef GRF_BYPASS_EN
        if (we && wa != 0 && a == wa) return !(iss_en && iss_addr == wa);
`endif
        return !m_pend[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_rd1",     rd1,                   m_rd(ra1));
            chk("cyc_rd2",     rd2,                   m_rd(ra2));
            chk("cyc_rd1_rdy", 32'(rd1_rdy),          32'(m_rdy(ra1)));
            chk("cyc_rd2_rdy", 32'(rd2_rdy),          32'(m_rdy(ra2)));
            chk("cyc_pend",    32'(pend_cnt),         32'(m_count()));
        end
    end

    task automatic edge_then_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0; we = 1'b0; iss_addr = '0; wa = '0; wd = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra1 = '0; ra2 = '0;
        idle();
        #2;
        chk("reset_pend", 32'(pend_cnt), 32'd0);
        #10 rst_n = 1'b1;
        cmp_en = 1'b1;

        // All addresses read zero and ready after reset
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd1, 32'd0);
            chk("rst_rdy1", 32'(rd1_rdy), 32'd1);
            chk("rst_rd2", rd2, 32'd0);
            chk("rst_pend", 32'(pend_cnt), 32'd0);
        end

        // Issue r5, then write it back
        edge_then_drive();
        iss_en = 1'b1; iss_addr = 5'd5;
        edge_then_drive();
        idle(); ra1 = 5'd5;
        #1;
        chk("r5_rdy_pending", 32'(rd1_rdy), 32'd0);
        chk("r5_pend_cnt1", 32'(pend_cnt), 32'd1);
        we = 1'b1; wa = 5'd5; wd = 32'd63;
        edge_then_drive();
        idle();
        #1;
        chk("r5_rd", rd1, 32'd63);
        chk("r5_rdy", 32'(rd1_rdy), 32'd1);
        chk("r5_pend_cnt0", 32'(pend_cnt), 32'd0);

        // Writes to r0 are dropped
        we = 1'b1; wa = 5'd0; wd = 32'd12; ra1 = 5'd0;
        #1;
        chk("r0_rd_same", rd1, 32'd0);
        chk("r0_rdy", 32'(rd1_rdy), 32'd1);
        edge_then_drive();
        idle();
        #1;
        chk("r0_rd", rd1, 32'd0);
        chk("r0_pend", 32'(pend_cnt), 32'd0);

        // Issue and write r7 together: data lands, register stays pending
        iss_en = 1'b1; iss_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'd75;
        edge_then_drive();
        idle(); ra1 = 5'd7;
        #1;
        chk("r7_rd", rd1, 32'd75);
        chk("r7_rdy", 32'(rd1_rdy), 32'd0);
        chk("r7_pend", 32'(pend_cnt), 32'd1);

        // Same-cycle write r3 observed on read port 2
        we = 1'b1; wa = 5'd3; wd = 32'd5;
        edge_then_drive();
        we = 1'b1; wa = 5'd3; wd = 32'd12; ra2 = 5'd3;
        #1;
`ifdef GRF_BYPASS_EN
        chk("r3_bypass_rd", rd2, 32'd12);
`else
        chk("r3_old_rd", rd2, 32'd5);
`endif
        chk("r3_rdy", 32'(rd2_rdy), 32'd1);
        edge_then_drive();
        idle();
        #1;
        chk("r3_rd_after", rd2, 32'd12);

        // Fill every register's pending bit, then reset mid-cycle
        for (int i = 1; i < 32; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            edge_then_drive();
        end
        idle();
        #1;
        chk("fill_pend31", 32'(pend_cnt), 32'd31);
        we = 1'b1; wa = 5'd9; wd = 32'hdead_beef; iss_en = 1'b1; iss_addr = 5'd9;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pend0", 32'(pend_cnt), 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            chk("async_rd0", rd1, 32'd0);
            chk("async_rdy", 32'(rd1_rdy), 32'd1);
        end
        idle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        ra1 = 5'd9;
        #1;
        chk("post_rst_r9", rd1, 32'd0);
        chk("post_rst_pend", 32'(pend_cnt), 32'd0);

        // Randomized traffic; narrow address window half the time for collisions
        for (int c = 0; c < 3000; c++) begin
            edge_then_drive();
            if ($urandom_range(0, 1) == 0) begin
                ra1      = 5'($urandom_range(0, 7));
                ra2      = 5'($urandom_range(0, 7));
                iss_addr = 5'($urandom_range(0, 7));
                wa       = 5'($urandom_range(0, 7));
            end else begin
                ra1      = 5'($urandom);
                ra2      = 5'($urandom);
                iss_addr = 5'($urandom);
                wa       = 5'($urandom);
            end
            iss_en = ($urandom_range(0, 99) < 45);
            we     = ($urandom_range(0, 99) < 40);
            wd     = $urandom;
        end
        edge_then_drive();
        idle();
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register width, equal to the ALU operand width (A, B, C).
REQ-002 Parameter NREG, default 32, register count; address width ADDR_W = 5.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port ra1  input  5  read address, port 1 (drives ALU operand A).
REQ-006 Port ra2  input  5  read address, port 2 (drives ALU operand B).
REQ-007 Port rd1  output  32  read data, port 1.
REQ-008 Port rd2  output  32  read data, port 2.
REQ-009 Port rd1_rdy  output  1  high when register ra1 has no pending producer.
REQ-010 Port rd2_rdy  output  1  high when register ra2 has no pending producer.
REQ-011 Port iss_en  input  1  issue strobe: mark iss_addr as pending.
REQ-012 Port iss_addr  input  5  destination register of the issued instruction.
REQ-013 Port we  input  1  writeback strobe, carrying the ALU result C.
REQ-014 Port wa  input  5  writeback address.
REQ-015 Port wd  input  32  writeback data.
REQ-016 Port pend_cnt  output  6  number of registers currently pending, range 0..31.

Function
REQ-017 Reads are combinational, with zero-cycle latency, from the register array.
REQ-018 Register 0 reads 0 and is always ready; writes and issues to address 0 are ignored.
REQ-019 we=1 with wa!=0 writes wd into register wa at the clock edge and clears pending[wa].
REQ-020 iss_en=1 with iss_addr!=0 sets pending[iss_addr] at the clock edge.
REQ-021 When iss_en and we target the same nonzero address in one cycle, the data is written and pending stays set (the new producer wins).
REQ-022 A writeback to a non-pending register still writes the data; pending stays clear.
REQ-023 An issue to an already-pending register leaves it pending; the count does not change.
REQ-024 pend_cnt is registered and updates in the same edge as the pending bits.
- Change per edge: +1 for a set from 0, -1 for a clear from 1, net 0 when both apply.
- Never wraps.
REQ-025 rdN_rdy = ~pending[raN], subject to REQ-018 and REQ-031.

Reset
REQ-026 While rst_n=0:
- all registers are 0;
- all pending bits are 0;
- pend_cnt is 0;
- this takes effect immediately, without a clock edge.
REQ-027 Reset asserted mid-operation discards any same-cycle write or issue.
REQ-028 After rst_n is released, the first state update occurs at the next rising edge.

Configuration
REQ-029 The macro GRF_BYPASS_EN controls write-to-read forwarding.
REQ-030 Without GRF_BYPASS_EN:
- a read in the writeback cycle returns the old register value;
- rdN_rdy reflects the pre-edge pending bit.
REQ-031 With GRF_BYPASS_EN, when we=1, wa!=0 and raN==wa:
- rdN=wd;
- rdN_rdy=1, unless iss_en targets the same address in that cycle, in which case rdN_rdy=0.

Structure
REQ-032 Package grf_pkg holds DATA_W, ADDR_W, NREG and the register-array typedef.
REQ-033 Sub-module grf_pending holds the pending bit vector and the pend_cnt counter.
REQ-034 grf_scoreboard instantiates grf_pending and holds the data array plus the read and bypass muxes.

Verification
REQ-035 Reset, then read all 32 addresses: rd=0, rdy=1, pend_cnt=0.
REQ-036 Issue r5, next cycle: rd1_rdy(ra1=5)=0, pend_cnt=1. Then we/wa=5/wd=63: rd1=63, rdy=1, pend_cnt=0.
REQ-037 Write wa=0, wd=12: ra1=0 returns 0 and rdy=1; pend_cnt unchanged.
REQ-038 Issue and write r7 (wd=75) in the same cycle: r7=75 and pending=1 afterwards; pend_cnt is +1.
REQ-039 Same-cycle write r3=12 with ra2=3:
- with GRF_BYPASS_EN: rd2=12, rdy=1;
- without it: rd2 holds the old value.
REQ-040 Issue r1..r31, then pulse rst_n low mid-cycle: pend_cnt reaches 31, then drops to 0 asynchronously and all registers read 0.
